// File: rtl/seq_detect_1011.sv
// Serial detector for the pattern 1011 (oldest bit first) on a qualified bit stream.
// Registered one-cycle match pulse plus a saturating match counter.
module seq_detect_1011 #(
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             bit_en,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StOne    = 3'd1,
    StTen    = 3'd2,
    StTenOne = 3'd3,
    StFull   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    case (state_q)
      StIdle:   if (bit_en) state_d = din ? StOne : StIdle;
      StOne:    if (bit_en) state_d = din ? StOne : StTen;
      StTen:    if (bit_en) state_d = din ? StTenOne : StIdle;
      StTenOne: begin
        if (bit_en) begin
          state_d = din ? StFull : StTen;
          match_d = din;
        end
      end
      // Without overlap a trailing "10" must not seed the next match.
      StFull:   if (bit_en) state_d = din ? StOne : ((OVERLAP != 0) ? StTen : StIdle);
      // Unused codes recover even while bit_en is low.
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Bench for seq_detect_1011: three instances (overlap, non-overlap, 2-bit counter) share
// one stimulus stream and are checked against a history-based reference model.
module tb_seq_detect_1011;

  logic clk = 1'b0;
  logic rst, din, bit_en, clr;

  logic       m0, m1, m2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [2:0] s0, s1, s2;

  always #5 clk = ~clk;

  seq_detect_1011 #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .din(din), .bit_en(bit_en), .clr(clr),
    .match(m0), .match_cnt(c0), .state_o(s0)
  );
  seq_detect_1011 #(.OVERLAP(0), .CNT_W(8)) dut_nov (
    .clk(clk), .rst(rst), .din(din), .bit_en(bit_en), .clr(clr),
    .match(m1), .match_cnt(c1), .state_o(s1)
  );
  seq_detect_1011 #(.OVERLAP(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .bit_en(bit_en), .clr(clr),
    .match(m2), .match_cnt(c2), .state_o(s2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: last accepted bits (newest in bit 0) and how many are valid.
  int ovl    [3] = '{1, 0, 0};
  int cntmax [3] = '{255, 255, 3};
  int hv     [3];
  int hl     [3];
  int justm  [3];
  int em     [3];
  int ecnt   [3];
  int est    [3];

  // Longest suffix of the history that is a prefix of 1011.
  function automatic int prefix_len(input int v, input int len);
    for (int k = 4; k >= 1; k--) begin
      if (len >= k && ((v & ((1 << k) - 1)) == (11 >> (4 - k)))) return k;
    end
    return 0;
  endfunction

  task automatic model_edge(input logic d, input logic en, input logic c, input logic r);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        hv[i] = 0; hl[i] = 0; justm[i] = 0; em[i] = 0; ecnt[i] = 0; est[i] = 0;
      end else begin
        em[i] = 0;
        if (en) begin
          if (ovl[i] == 0 && justm[i] != 0) begin
            hv[i] = 0; hl[i] = 0;
          end
          hv[i] = ((hv[i] << 1) | int'(d)) & 15;
          if (hl[i] < 4) hl[i]++;
          est[i]   = prefix_len(hv[i], hl[i]);
          justm[i] = (est[i] == 4) ? 1 : 0;
          em[i]    = justm[i];
        end
        if (c) ecnt[i] = 0;
        else if (em[i] != 0 && ecnt[i] < cntmax[i]) ecnt[i]++;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic en, input logic c, input logic r);
    din = d; bit_en = en; clr = c; rst = r;
    @(posedge clk);
    model_edge(d, en, c, r);
    #1;
    check("ov.state",   int'(s0), est[0]);
    check("ov.match",   int'(m0), em[0]);
    check("ov.cnt",     int'(c0), ecnt[0]);
    check("nov.state",  int'(s1), est[1]);
    check("nov.match",  int'(m1), em[1]);
    check("nov.cnt",    int'(c1), ecnt[1]);
    check("sat.state",  int'(s2), est[2]);
    check("sat.match",  int'(m2), em[2]);
    check("sat.cnt",    int'(c2), ecnt[2]);
  endtask

  task automatic send(input logic [3:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(bits[k], 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    din = 1'b0; bit_en = 1'b0; clr = 1'b0; rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-pattern, then a single 1.
    send(4'b0101, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("plan.rst_state", int'(s0), 1);
    check("plan.rst_cnt",   int'(c0), 0);

    // 1011011: two matches with overlap, one without.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b1011, 4);
    send(4'b0011, 3);
    check("plan.ov_cnt",    int'(c0), 2);
    check("plan.ov_state",  int'(s0), 4);
    check("plan.nov_cnt",   int'(c1), 1);
    check("plan.nov_state", int'(s1), 1);

    // Gating: hold S3 across a disabled gap with din toggling.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b0101, 3);
    for (int k = 0; k < 5; k++) begin
      step(1'(k & 1), 1'b0, 1'b0, 1'b0);
      check("plan.gap_state", int'(s0), 3);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("plan.gap_match", int'(m0), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("plan.gap_hold_match", int'(m0), 0);

    // Saturation of the 2-bit counter.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send(4'b1011, 4);
      check("plan.sat_cnt", int'(c2), (k < 3) ? k + 1 : 3);
    end

    // clr on the matching edge.
    send(4'b0101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("plan.clr_match", int'(m0), 1);
    check("plan.clr_cnt",   int'(c0), 0);
    check("plan.clr_state", int'(s0), 4);

    // Random traffic, biased towards 1s so matches are frequent.
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_1011.md
Name: seq_detect_1011

Overview:
- Moore-style serial pattern detector that consumes the registered bit stream produced by the master-slave D flip-flop stage (its q output).
- Watches the stream for the pattern 1011, oldest bit first.
- Emits a one-cycle match pulse and keeps a saturating count of matches.
- Sits directly downstream of the flip-flop. Feeds status/debug logic.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (a match suffix may start the next match); 0 = restart from idle after each match.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit; driven from upstream flip-flop q.
- bit_en  input  1  qualifies din; the FSM advances only on edges where bit_en=1.
- clr  input  1  synchronous clear of match_cnt only.
- match  output  1  one-cycle pulse; pattern 1011 completed.
- match_cnt  output  CNT_W  number of matches since reset/clr; saturating.
- state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Interface: one clock (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset (rst=1 at edge): state=S0, match=0, match_cnt=0, state_o=3'd0. rst has priority over everything, including mid-pattern states.
- State encoding:
  - S0=0: idle.
  - S1=1: seen "1".
  - S2=2: seen "10".
  - S3=3: seen "101".
  - S4=4: seen "1011".
  - Codes 5-7 are illegal and return to S0 on the next edge regardless of bit_en.
- Transitions on an edge with bit_en=1:
  - S0: din=1 -> S1; din=0 -> S0.
  - S1: din=1 -> S1; din=0 -> S2.
  - S2: din=1 -> S3; din=0 -> S0.
  - S3: din=1 -> S4; din=0 -> S2.
  - S4 with OVERLAP=1: din=1 -> S1; din=0 -> S2.
  - S4 with OVERLAP=0: din=1 -> S1; din=0 -> S0.
- bit_en=0: state holds (illegal codes still recover). match=0.
- match:
  - Registered. Asserts for exactly one cycle, the cycle after the edge where the state transitions S3 -> S4.
  - Does not re-assert while S4 is held with bit_en=0.
  - Latency: last pattern bit sampled at edge N -> match=1 during cycle N..N+1.
- match_cnt:
  - Increments on the same edge that sets match.
  - Saturates at 2^CNT_W-1; no wrap.
- clr:
  - Sets match_cnt=0 at the edge and does not affect the state or match.
  - If clr and a match occur on the same edge, clr wins: match_cnt=0 and match=1.
- state_o: direct copy of the state register, zero-extended to 3 bits.
- No combinational path from din to any output.

Test Plan:
- Reset mid-pattern: drive 1,0,1 with bit_en=1, then rst=1 for one edge, then 1 -> state_o=1 (S1), match never asserted, match_cnt=0.
- OVERLAP=1, stream 1,0,1,1,0,1,1 with bit_en=1 every cycle -> match pulses after bits 4 and 7, each exactly one cycle wide; match_cnt=2; final state_o=4.
- OVERLAP=0, same stream 1,0,1,1,0,1,1 -> single match after bit 4; match_cnt=1; final state_o=1.
- Gating: 1,0,1 then bit_en=0 for 5 cycles with din toggling, then bit_en=1 with din=1 -> state_o holds 3 during the gap; match=1 exactly once, after the final edge.
- Saturation (CNT_W=2): repeat 1011 five times, non-overlapping -> match_cnt sequence 1,2,3,3,3; match pulses five times.
- clr collision: in state S3, drive din=1, bit_en=1 and clr=1 on the same edge -> match=1, match_cnt=0, state_o=4.
